// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for seven_seg_scan: captured display request in,
// multiplexed segment/anode drive and frame pulse out.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output value, dp_in, digit_en, lz_blank, load,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  value, dp_in, digit_en, lz_blank, load,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with frame-synchronous updates,
// inter-digit blanking, leading-zero suppression and selectable polarity.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input logic         clk,
    input logic         reset,
    seven_seg_scan_if.slave bus
);
    localparam int PC_W = $clog2(REFRESH_DIV);
    localparam int D_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW   = 4 * NUM_DIGITS;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(REFRESH_DIV - 1);
    localparam logic [D_W-1:0]  D_LAST  = D_W'(NUM_DIGITS - 1);

    logic [PC_W-1:0]       pc;
    logic [D_W-1:0]        d;
    logic [VW-1:0]         pend_value, act_value;
    logic [NUM_DIGITS-1:0] pend_dp, pend_en, act_dp, act_en;
    logic                  pend_lz, act_lz, pend_flag;

    logic                  wrap, boundary, in_blank, blank;
    logic [3:0]            nib;
    logic                  en_sel, dp_sel, lz_sel, upper_zero;
    logic [NUM_DIGITS-1:0] an_sel, an_l;
    logic [6:0]            seg_l;
    logic                  dp_l;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  ft_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        case (h)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    assign wrap     = (pc == PC_LAST);
    assign boundary = wrap && (d == D_LAST);

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank = (pc < PC_W'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign in_blank = 1'b0;
        end
    endgenerate

    // Walk from the top digit down so upper_zero covers nibbles i..N-1 at digit i.
    always_comb begin
        nib        = 4'h0;
        en_sel     = 1'b0;
        dp_sel     = 1'b0;
        lz_sel     = 1'b0;
        upper_zero = 1'b1;
        an_sel     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (act_value[4*i +: 4] == 4'h0);
            if (d == D_W'(i)) begin
                nib       = act_value[4*i +: 4];
                en_sel    = act_en[i];
                dp_sel    = act_dp[i];
                lz_sel    = (i != 0) && upper_zero;
                an_sel[i] = 1'b1;
            end
        end
    end

    assign blank = ~en_sel | (act_lz & lz_sel) | in_blank;
    assign seg_l = blank ? 7'h00 : seg_decode(nib);
    assign dp_l  = dp_sel & ~blank;
    assign an_l  = in_blank ? '0 : an_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            d          <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_lz    <= 1'b0;
            pend_flag  <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            act_lz     <= 1'b0;
        end else begin
            pc <= wrap ? '0 : pc + PC_W'(1);
            if (wrap) begin
                d <= (d == D_LAST) ? '0 : d + D_W'(1);
            end
            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_en    <= bus.digit_en;
                pend_lz    <= bus.lz_blank;
                pend_flag  <= 1'b1;
            end
            // A load on the boundary bypasses pending and also leaves the flag clear.
            if (boundary && (bus.load || pend_flag)) begin
                act_value <= bus.load ? bus.value    : pend_value;
                act_dp    <= bus.load ? bus.dp_in    : pend_dp;
                act_en    <= bus.load ? bus.digit_en : pend_en;
                act_lz    <= bus.load ? bus.lz_blank : pend_lz;
                pend_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= {7{ACTIVE_LOW}};
            dp_q  <= ACTIVE_LOW;
            an_q  <= {NUM_DIGITS{ACTIVE_LOW}};
            ft_q  <= 1'b0;
        end else begin
            seg_q <= seg_l ^ {7{ACTIVE_LOW}};
            dp_q  <= dp_l ^ ACTIVE_LOW;
            an_q  <= an_l ^ {NUM_DIGITS{ACTIVE_LOW}};
            ft_q  <= boundary;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = ft_q;
endmodule
